// File: rtl/score_argmax_collector.sv
// Collects NUM_CLASSES signed scores per frame and reports the index and value of the maximum.
// Optional macro ARGMAX_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module score_argmax_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 8,
  parameter int IDX_WIDTH   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  result_ready,
  output logic                  result_valid,
  output logic [IDX_WIDTH-1:0]  result_class,
  output logic [DATA_WIDTH-1:0] result_score,
`ifdef ARGMAX_FRAME_CNT_EN
  output logic [7:0]            frame_count,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [IDX_WIDTH-1:0]  cnt;
  logic [IDX_WIDTH-1:0]  max_idx;
  logic [DATA_WIDTH-1:0] max_score;
  logic                  accept;
  logic                  last_beat;
  logic                  greater;

  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt == LAST_IDX);
  assign greater   = ($signed(in_data) > $signed(max_score));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = COLLECT;
      end
      COLLECT: begin
        busy     = 1'b1;
        in_ready = enable;
        if (!enable) begin
          state_nxt = IDLE;
        end else if (accept && last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // enable is deliberately ignored here so a finished result is never lost
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      max_idx   <= '0;
      max_score <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) cnt <= '0;
        end
        COLLECT: begin
          if (!enable) begin
            cnt       <= '0;
            max_idx   <= '0;
            max_score <= '0;
          end else if (accept) begin
            // beat 0 seeds the max; strict compare keeps the lowest index on ties
            if (cnt == '0 || greater) begin
              max_score <= in_data;
              max_idx   <= cnt;
            end
            if (!last_beat) cnt <= cnt + IDX_WIDTH'(1);
          end
        end
        DONE: begin
          if (result_ready) cnt <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign result_class = max_idx;
  assign result_score = max_score;

`ifdef ARGMAX_FRAME_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (result_valid && result_ready) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_score_argmax_collector.sv
// Directed and randomized frames for score_argmax_collector, checked against a plain argmax model.
module tb_score_argmax_collector;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        result_ready;
  logic        result_valid;
  logic [2:0]  result_class;
  logic [15:0] result_score;
  logic        busy;
`ifdef ARGMAX_FRAME_CNT_EN
  logic [7:0]  frame_count;
`endif

  int tests = 0;
  int fails = 0;
  int fc_exp = 0;

  score_argmax_collector #(
    .DATA_WIDTH(16),
    .NUM_CLASSES(8),
    .IDX_WIDTH(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .result_ready(result_ready),
    .result_valid(result_valid),
    .result_class(result_class),
    .result_score(result_score),
`ifdef ARGMAX_FRAME_CNT_EN
    .frame_count(frame_count),
`endif
    .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first occurrence of the largest value.
  task automatic model(input int s[8], output int idx, output int mx);
    idx = 0;
    mx  = s[0];
    for (int i = 1; i < 8; i++) begin
      if (s[i] > mx) begin
        mx  = s[i];
        idx = i;
      end
    end
  endtask

  task automatic start_frame();
    enable = 1'b1;
    @(negedge clock);
    chk("start_busy", 16'(busy), 16'd1);
    chk("start_in_ready", 16'(in_ready), 16'd1);
  endtask

  task automatic stream(input int s[8], input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
      in_valid = 1'b1;
      in_data  = 16'(s[i]);
      @(negedge clock);
      if (i < 7) chk("no_early_valid", 16'(result_valid), 16'd0);
    end
    in_valid = 1'b0;
    chk("valid_after_last", 16'(result_valid), 16'd1);
  endtask

  task automatic check_result(input int s[8]);
    int idx;
    int mx;
    model(s, idx, mx);
    chk("result_class", 16'(result_class), 16'(idx));
    chk("result_score", result_score, 16'(mx));
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(negedge clock);
    chk("consumed_valid", 16'(result_valid), 16'd0);
    chk("consumed_busy", 16'(busy), 16'd0);
    result_ready = 1'b0;
    fc_exp++;
  endtask

  task automatic run_frame(input int s[8], input bit gaps);
    start_frame();
    stream(s, gaps);
    check_result(s);
    consume();
  endtask

  task automatic rand_scores(input bit narrow, output int s[8]);
    for (int i = 0; i < 8; i++) begin
      if (narrow) s[i] = int'($urandom_range(0, 3)) - 2;
      else        s[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  initial begin
    int s[8];
    int idx;
    int mx;

    reset = 1'b0;
    enable = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    result_ready = 1'b0;
    #12;
    chk("rst_valid", 16'(result_valid), 16'd0);
    chk("rst_class", 16'(result_class), 16'd0);
    chk("rst_score", result_score, 16'd0);
    chk("rst_in_ready", 16'(in_ready), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    @(negedge clock);
    reset = 1'b1;

    // Scores offered while idle must be dropped.
    in_valid = 1'b1;
    in_data  = 16'h7fff;
    repeat (3) @(negedge clock);
    chk("idle_in_ready", 16'(in_ready), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
    in_valid = 1'b0;

    s = '{5, -3, 12, 7, 0, 12, -1, 2};
    run_frame(s, 1'b0);
    chk("tie_class_is_2", 16'(dut.result_class), 16'd2);

    s = '{-8, -2, -9, -2, -100, -5, -7, -3};
    run_frame(s, 1'b1);

    // Abort after four beats; no result may appear.
    start_frame();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(100 + i);
      @(negedge clock);
    end
    enable   = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_valid", 16'(result_valid), 16'd0);
    repeat (3) @(negedge clock);
    chk("abort_no_result", 16'(result_valid), 16'd0);
    s = '{0, 0, 0, 0, 0, 0, 0, 9};
    run_frame(s, 1'b0);

    // Back-pressure in DONE with enable low and in_valid high.
    rand_scores(1'b0, s);
    model(s, idx, mx);
    start_frame();
    stream(s, 1'b0);
    enable   = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h7fff;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("hold_valid", 16'(result_valid), 16'd1);
      chk("hold_class", 16'(result_class), 16'(idx));
      chk("hold_score", result_score, 16'(mx));
      chk("hold_in_ready", 16'(in_ready), 16'd0);
    end
    consume();
    in_valid = 1'b0;

    // Asynchronous reset mid-collect after three beats.
    start_frame();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(50 + i);
      @(negedge clock);
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 16'(result_valid), 16'd0);
    chk("arst_class", 16'(result_class), 16'd0);
    chk("arst_score", result_score, 16'd0);
    chk("arst_in_ready", 16'(in_ready), 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    enable = 1'b0;
    fc_exp = 0;
    #1 reset = 1'b1;
    @(negedge clock);
    s = '{3, 1, 4, 1, 5, 9, 2, 6};
    run_frame(s, 1'b0);

    for (int f = 0; f < 8; f++) begin
      rand_scores(f[0], s);
      run_frame(s, f[1]);
    end

`ifdef ARGMAX_FRAME_CNT_EN
    for (int f = 0; f < 257; f++) begin
      rand_scores(1'b1, s);
      run_frame(s, 1'b0);
    end
    start_frame();
    in_valid = 1'b1;
    in_data  = 16'd1;
    @(negedge clock);
    enable   = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("frame_count", 16'(frame_count), 16'(fc_exp % 256));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
